rs_syndrome_calc: RTL and testbench
===================================

Name: rs_syndrome_calc

Overview:
- Decoder-side counterpart of the RS(255,239) parity LFSR: computes the 16 syndromes S_0..S_15 of a received byte-serial codeword over GF(2^8).
- Sits at the head of the RS decode chain and feeds the key-equation solver.
- Uses the same field as the encoder: primitive polynomial x^8+x^4+x^3+x^2+1 (0x11D), alpha = 0x02.
- Syndrome roots are alpha^(FCR+i), i = 0..15.

Parameters:
N, 255, codeword length in symbols (data plus parity)
NSYN, 16, number of syndromes (2t)
FCR, 0, first consecutive root exponent

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-low (rst=0 resets on the rising clk edge)
in_valid  input  1  in_data is a valid received symbol this cycle
in_sop  input  1  first symbol of the codeword; qualified by in_valid
in_eop  input  1  last symbol of the codeword; qualified by in_valid
in_data  input  8  received symbol, highest-degree coefficient first
syn_valid  output  1  one-cycle pulse: syndromes and flags valid
syn  output  8*NSYN  S_i in bits [8i+7:8i]; held until the next syn_valid
syn_nonzero  output  1  OR of all syndromes; held with syn
len_err  output  1  symbol count of the last frame != N; held with syn
frame_abort  output  1  one-cycle pulse: open frame restarted by a new in_sop

Behaviour:
- Reset (rst=0 at posedge):
  - state=IDLE; all accumulators, syn, counter = 0.
  - syn_valid, syn_nonzero, len_err, frame_abort = 0.
- States: IDLE, ACCUM.
- Accumulate (Horner), on each cycle with in_valid=1:
  - in_sop=1: A_i <= in_data; cnt <= 1.
  - in_sop=0 in ACCUM: A_i <= (A_i * alpha^(FCR+i)) ^ in_data; cnt <= cnt+1.
  - Multiply is a constant GF(2^8) XOR network, combinational, same cycle.
- Transitions:
  - IDLE -> ACCUM on in_valid & in_sop & !in_eop.
  - ACCUM -> IDLE on in_valid & in_eop.
  - in_valid=0 cycles are stalls: state, A_i and cnt hold.
  - in_valid & !in_sop in IDLE: symbol ignored, no state change.
- Output, eop symbol accepted at cycle t:
  - At t+1: syn_valid=1 for exactly one cycle.
  - syn = final A_i values, including the eop symbol.
  - syn_nonzero = |syn.
  - len_err = (final cnt != N).
- Counter width 9 bits; saturates at 511, no wrap.
- in_sop & in_eop in the same cycle: one-symbol frame.
  - syn = in_data replicated in every S_i.
  - len_err=1 unless N=1.
- in_sop while in ACCUM (no eop yet): accumulators restart with in_data; frame_abort pulses at t+1; no syn_valid for the aborted frame.
- Back-to-back frames: in_sop is accepted the cycle after eop, with zero bubble. syn_valid of the previous frame may coincide with the first accumulate cycle of the next.
- syn and flags update only on syn_valid.
- Reset mid-frame discards the partial frame; no syn_valid is produced.
- No back-pressure: always ready; downstream must capture syn on syn_valid or before the next syn_valid.

Optional Feature:
- Macro RS_SYN_ERRCNT_EN.
- Defined:
  - Adds output port err_frame_cnt [31:0]: count of completed frames with syn_nonzero=1 or len_err=1.
  - Increments in the syn_valid cycle; saturates at 0xFFFFFFFF; cleared by rst.
  - Adds input err_cnt_clr (1 bit): synchronous clear. If it coincides with an increment, the result is 1.
- Undefined: neither port exists and no counter logic is built.

Test Plan:
- 255 symbols all 0x00, sop on first, eop on last -> one cycle after eop: syn_valid=1, all S_i=0x00, syn_nonzero=0, len_err=0.
- 254 zeros then 0x05 as the last symbol -> all 16 S_i=0x05, syn_nonzero=1, len_err=0.
- 0x01 as the first symbol, then 254 zeros, FCR=0 -> S_0=0x01, S_1=0x8E (alpha^254).
- Valid RS(255,239) codeword from the team's encoder model, with in_valid gapped randomly -> all S_i=0x00. Flip byte 10 by 0x3C -> syn_nonzero=1, S_0=0x3C.
- 200-symbol frame -> len_err=1.
- sop, 50 symbols, second sop, then a full 255-symbol frame -> frame_abort pulse, then exactly one syn_valid with len_err=0.
- Back-to-back: two codewords with no gap between eop and sop -> two syn_valid pulses exactly 255 cycles apart, each with correct syndromes.
- rst=0 asserted at symbol 100 of a frame -> no syn_valid; all outputs read 0 afterwards.

Source files
------------

// File: rtl/rs_syndrome_calc.sv
// RS(255,239) syndrome calculator over GF(2^8), poly 0x11D, alpha=0x02.
// Optional error-frame counter: define RS_SYN_ERRCNT_EN.
module rs_syndrome_calc #(
  parameter int N    = 255,
  parameter int NSYN = 16,
  parameter int FCR  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic [7:0]        in_data,
  output logic              syn_valid,
  output logic [8*NSYN-1:0] syn,
  output logic              syn_nonzero,
  output logic              len_err,
  output logic              frame_abort
`ifdef RS_SYN_ERRCNT_EN
  ,
  input  logic              err_cnt_clr,
  output logic [31:0]       err_frame_cnt
`endif
);

  typedef enum logic {
    IDLE,
    ACCUM
  } state_e;

  localparam logic [8:0] NLEN = 9'(N);

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
  endfunction

  function automatic logic [7:0] apow(input int k);
    logic [7:0] r;
    r = 8'h01;
    for (int j = 0; j < k; j++) r = xt(r);
    return r;
  endfunction

  // Multiply by a constant: folds into a fixed XOR network.
  function automatic logic [7:0] cmul(
    input logic [7:0] a,
    input logic [7:0] c
  );
    logic [7:0] r;
    logic [7:0] x;
    r = 8'h00;
    x = c;
    for (int j = 0; j < 8; j++) begin
      if (a[j]) r = r ^ x;
      x = xt(x);
    end
    return r;
  endfunction

  state_e                     state_q;
  logic [NSYN-1:0][7:0]       acc_q;
  logic [NSYN-1:0][7:0]       acc_d;
  logic [8:0]                 cnt_q;
  logic [8:0]                 cnt_d;

  for (genvar i = 0; i < NSYN; i++) begin : g_root
    localparam logic [7:0] ROOT = apow((FCR + i) % 255);
    assign acc_d[i] = cmul(acc_q[i], ROOT) ^ in_data;
  end

  assign cnt_d = (cnt_q == 9'h1FF) ? cnt_q : cnt_q + 9'd1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      syn         <= '0;
      syn_valid   <= 1'b0;
      syn_nonzero <= 1'b0;
      len_err     <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      syn_valid   <= 1'b0;
      frame_abort <= 1'b0;
      if (in_valid) begin
        if (in_sop) begin
          acc_q       <= {NSYN{in_data}};
          cnt_q       <= 9'd1;
          frame_abort <= (state_q == ACCUM);
          if (in_eop) begin
            state_q     <= IDLE;
            syn_valid   <= 1'b1;
            syn         <= {NSYN{in_data}};
            syn_nonzero <= |in_data;
            len_err     <= (NLEN != 9'd1);
          end else begin
            state_q <= ACCUM;
          end
        end else if (state_q == ACCUM) begin
          acc_q <= acc_d;
          cnt_q <= cnt_d;
          if (in_eop) begin
            state_q     <= IDLE;
            syn_valid   <= 1'b1;
            syn         <= acc_d;
            syn_nonzero <= |acc_d;
            len_err     <= (cnt_d != NLEN);
          end
        end
      end
    end
  end

`ifdef RS_SYN_ERRCNT_EN
  logic [31:0] errc_q;
  logic        err_inc;

  assign err_inc       = syn_valid & (syn_nonzero | len_err);
  assign err_frame_cnt = errc_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      errc_q <= '0;
    end else if (err_cnt_clr) begin
      errc_q <= {31'd0, err_inc};
    end else if (err_inc && errc_q != 32'hFFFF_FFFF) begin
      errc_q <= errc_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rs_syndrome_calc.sv
// Directed bench for rs_syndrome_calc: hand-derived syndromes plus
// codewords from a small systematic RS(255,239) encoder model.
module tb_rs_syndrome_calc;
  localparam int N    = 255;
  localparam int NSYN = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_sop = 1'b0;
  logic              in_eop = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              syn_valid;
  logic [8*NSYN-1:0] syn;
  logic              syn_nonzero;
  logic              len_err;
  logic              frame_abort;
`ifdef RS_SYN_ERRCNT_EN
  logic              err_cnt_clr = 1'b0;
  logic [31:0]       err_frame_cnt;
`endif

  int checks = 0;
  int failures = 0;

  rs_syndrome_calc #(.N(N), .NSYN(NSYN), .FCR(0)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_sop      (in_sop),
    .in_eop      (in_eop),
    .in_data     (in_data),
    .syn_valid   (syn_valid),
    .syn         (syn),
    .syn_nonzero (syn_nonzero),
    .len_err     (len_err),
    .frame_abort (frame_abort)
`ifdef RS_SYN_ERRCNT_EN
    ,
    .err_cnt_clr   (err_cnt_clr),
    .err_frame_cnt (err_frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int                sv_cnt = 0;
  int                ab_cnt = 0;
  int                sv_cyc_last = 0;
  int                sv_cyc_prev = 0;
  logic [8*NSYN-1:0] cap_syn = '0;
  logic [8*NSYN-1:0] cap_prev_syn = '0;
  logic              cap_nz = 1'b0;
  logic              cap_le = 1'b0;

  always @(negedge clk) begin
    if (syn_valid) begin
      sv_cnt++;
      sv_cyc_prev  = sv_cyc_last;
      sv_cyc_last  = cyc;
      cap_prev_syn = cap_syn;
      cap_syn      = syn;
      cap_nz       = syn_nonzero;
      cap_le       = len_err;
    end
    if (frame_abort) ab_cnt++;
  end

  logic [7:0] fbuf  [0:511];
  logic [7:0] fbuf2 [0:511];
  logic [7:0] gen   [0:16];
  int         eop_cyc = 0;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] x;
    r = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) r = r ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
    end
    return r;
  endfunction

  task automatic build_gen();
    logic [7:0] a;
    for (int j = 0; j <= 16; j++) gen[j] = 8'h00;
    gen[0] = 8'h01;
    a = 8'h01;
    for (int i = 0; i < 16; i++) begin
      for (int j = 16; j >= 1; j--) gen[j] = gen[j-1] ^ gmul(gen[j], a);
      gen[0] = gmul(gen[0], a);
      a = gmul(a, 8'h02);
    end
  endtask

  // Fill fbuf (sel=0) or fbuf2 (sel=1) with a valid codeword.
  task automatic encode(input int seed, input bit sel);
    logic [7:0] p [0:15];
    logic [7:0] d;
    logic [7:0] fb;
    for (int j = 0; j < 16; j++) p[j] = 8'h00;
    for (int n = 0; n < 239; n++) begin
      d = 8'((n * 37 + seed * 11 + (n >> 3)) & 255);
      if (sel) fbuf2[n] = d;
      else fbuf[n] = d;
      fb = d ^ p[15];
      for (int j = 15; j >= 1; j--) p[j] = p[j-1] ^ gmul(fb, gen[j]);
      p[0] = gmul(fb, gen[0]);
    end
    for (int k = 0; k < 16; k++) begin
      if (sel) fbuf2[239+k] = p[15-k];
      else fbuf[239+k] = p[15-k];
    end
  endtask

  task automatic zero_buf();
    for (int i = 0; i < 512; i++) fbuf[i] = 8'h00;
  endtask

  task automatic drive(input logic v, input logic s, input logic e,
                       input logic [7:0] d);
    @(posedge clk);
    #1;
    in_valid = v;
    in_sop   = s;
    in_eop   = e;
    in_data  = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_frame(input int len, input bit gaps, input bit eop_en,
                            input bit sel);
    logic [7:0] d;
    for (int i = 0; i < len; i++) begin
      if (gaps && $urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 2)) drive(1'b0, 1'b0, 1'b0, 8'h55);
      d = sel ? fbuf2[i] : fbuf[i];
      drive(1'b1, i == 0, eop_en && (i == len - 1), d);
    end
    eop_cyc = cyc;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (syn_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_syn_valid got=%b want=0", syn_valid);
    end
    checks++;
    if (syn !== '0) begin
      failures++;
      $display("FAIL reset_syn got=%h want=0", syn);
    end
    checks++;
    if (syn_nonzero !== 1'b0 || len_err !== 1'b0 || frame_abort !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b%b%b want=000",
               syn_nonzero, len_err, frame_abort);
    end
  endtask

  task automatic test_zeros();
    int base;
    base = sv_cnt;
    zero_buf();
    send_frame(N, 1'b0, 1'b1, 1'b0);
    idle(3);
    checks++;
    if (sv_cnt - base !== 1) begin
      failures++;
      $display("FAIL zeros_pulses got=%0d want=1", sv_cnt - base);
    end
    checks++;
    if (sv_cyc_last !== eop_cyc + 1) begin
      failures++;
      $display("FAIL zeros_latency got=%0d want=%0d", sv_cyc_last, eop_cyc + 1);
    end
    checks++;
    if (cap_syn !== '0 || cap_nz !== 1'b0 || cap_le !== 1'b0) begin
      failures++;
      $display("FAIL zeros_syn got=%h nz=%b le=%b want=0 0 0",
               cap_syn, cap_nz, cap_le);
    end
  endtask

  task automatic test_last_sym();
    zero_buf();
    fbuf[254] = 8'h05;
    send_frame(N, 1'b0, 1'b1, 1'b0);
    idle(3);
    for (int i = 0; i < NSYN; i++) begin
      checks++;
      if (cap_syn[8*i +: 8] !== 8'h05) begin
        failures++;
        $display("FAIL last_sym_S%0d got=%h want=05", i, cap_syn[8*i +: 8]);
      end
    end
    checks++;
    if (cap_nz !== 1'b1 || cap_le !== 1'b0) begin
      failures++;
      $display("FAIL last_sym_flags got=nz%b le%b want=nz1 le0", cap_nz, cap_le);
    end
  endtask

  task automatic test_first_sym();
    zero_buf();
    fbuf[0] = 8'h01;
    send_frame(N, 1'b0, 1'b1, 1'b0);
    idle(3);
    checks++;
    if (cap_syn[7:0] !== 8'h01) begin
      failures++;
      $display("FAIL first_sym_S0 got=%h want=01", cap_syn[7:0]);
    end
    checks++;
    if (cap_syn[15:8] !== 8'h8E) begin
      failures++;
      $display("FAIL first_sym_S1 got=%h want=8e", cap_syn[15:8]);
    end
    checks++;
    if (cap_syn[23:16] !== 8'h47) begin
      failures++;
      $display("FAIL first_sym_S2 got=%h want=47", cap_syn[23:16]);
    end
  endtask

  task automatic test_codeword();
    encode(1, 1'b0);
    send_frame(N, 1'b1, 1'b1, 1'b0);
    idle(3);
    checks++;
    if (cap_syn !== '0 || cap_nz !== 1'b0 || cap_le !== 1'b0) begin
      failures++;
      $display("FAIL codeword_clean got=%h nz=%b le=%b want=0 0 0",
               cap_syn, cap_nz, cap_le);
    end
    fbuf[10] = fbuf[10] ^ 8'h3C;
    send_frame(N, 1'b1, 1'b1, 1'b0);
    idle(3);
    checks++;
    if (cap_syn[7:0] !== 8'h3C) begin
      failures++;
      $display("FAIL codeword_err_S0 got=%h want=3c", cap_syn[7:0]);
    end
    checks++;
    if (cap_nz !== 1'b1) begin
      failures++;
      $display("FAIL codeword_err_nz got=%b want=1", cap_nz);
    end
    fbuf[10] = fbuf[10] ^ 8'h3C;
  endtask

  task automatic test_short();
    int base;
    base = sv_cnt;
    zero_buf();
    send_frame(200, 1'b0, 1'b1, 1'b0);
    idle(3);
    checks++;
    if (sv_cnt - base !== 1 || cap_le !== 1'b1 || cap_nz !== 1'b0) begin
      failures++;
      $display("FAIL short_frame got=pulses%0d le%b nz%b want=pulses1 le1 nz0",
               sv_cnt - base, cap_le, cap_nz);
    end
  endtask

  task automatic test_single();
    drive(1'b1, 1'b1, 1'b1, 8'hA7);
    idle(3);
    checks++;
    if (cap_syn !== {NSYN{8'hA7}}) begin
      failures++;
      $display("FAIL single_syn got=%h want=all a7", cap_syn);
    end
    checks++;
    if (cap_le !== 1'b1 || cap_nz !== 1'b1) begin
      failures++;
      $display("FAIL single_flags got=le%b nz%b want=le1 nz1", cap_le, cap_nz);
    end
  endtask

  task automatic test_abort();
    int sb;
    int ab;
    encode(2, 1'b0);
    sb = sv_cnt;
    ab = ab_cnt;
    send_frame(50, 1'b0, 1'b0, 1'b0);
    send_frame(N, 1'b0, 1'b1, 1'b0);
    idle(3);
    checks++;
    if (ab_cnt - ab !== 1) begin
      failures++;
      $display("FAIL abort_pulse got=%0d want=1", ab_cnt - ab);
    end
    checks++;
    if (sv_cnt - sb !== 1) begin
      failures++;
      $display("FAIL abort_syn_valid got=%0d want=1", sv_cnt - sb);
    end
    checks++;
    if (cap_le !== 1'b0 || cap_syn !== '0) begin
      failures++;
      $display("FAIL abort_result got=le%b syn=%h want=le0 syn=0", cap_le, cap_syn);
    end
  endtask

  task automatic test_back_to_back();
    int sb;
    encode(3, 1'b0);
    encode(4, 1'b1);
    sb = sv_cnt;
    send_frame(N, 1'b0, 1'b1, 1'b0);
    send_frame(N, 1'b0, 1'b1, 1'b1);
    idle(3);
    checks++;
    if (sv_cnt - sb !== 2) begin
      failures++;
      $display("FAIL b2b_pulses got=%0d want=2", sv_cnt - sb);
    end
    checks++;
    if (sv_cyc_last - sv_cyc_prev !== N) begin
      failures++;
      $display("FAIL b2b_spacing got=%0d want=%0d", sv_cyc_last - sv_cyc_prev, N);
    end
    checks++;
    if (cap_prev_syn !== '0 || cap_syn !== '0) begin
      failures++;
      $display("FAIL b2b_syn got=%h/%h want=0/0", cap_prev_syn, cap_syn);
    end
  endtask

  task automatic test_reset_mid();
    int sb;
    drive(1'b1, 1'b1, 1'b1, 8'h3B);
    idle(2);
    encode(5, 1'b0);
    sb = sv_cnt;
    send_frame(100, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b1;
    in_sop = 1'b0;
    in_eop = 1'b0;
    in_data = fbuf[100];
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 101; i < N; i++)
      drive(1'b1, 1'b0, i == N - 1, fbuf[i]);
    idle(3);
    checks++;
    if (sv_cnt - sb !== 0) begin
      failures++;
      $display("FAIL rst_mid_pulses got=%0d want=0", sv_cnt - sb);
    end
    checks++;
    if (syn !== '0 || syn_nonzero !== 1'b0 || len_err !== 1'b0
        || frame_abort !== 1'b0 || syn_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_outputs got=syn%h nz%b le%b fa%b sv%b want=all 0",
               syn, syn_nonzero, len_err, frame_abort, syn_valid);
    end
  endtask

  initial begin
    build_gen();
    test_reset();
    test_zeros();
    test_last_sym();
    test_first_sym();
    test_codeword();
    test_short();
    test_single();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
